// File: rtl/mux_share_arbiter_pkg.sv
// Shared definitions for the mux_share_arbiter block.
// Holds the state encoding, parameter defaults and select polarity.
package mux_share_arbiter_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_HOLD  = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_X = 2'd1;
  localparam logic [1:0] ST_OWN_Y = 2'd2;

  localparam logic SEL_X = 1'b1;
  localparam logic SEL_Y = 1'b0;

endpackage

// File: rtl/mux_share_arbiter_hold_counter.sv
// Saturating 4-bit hold counter.
// Ports:
//   clk_i    - clock
//   rst_ni   - asynchronous active-low reset
//   clr_i    - synchronous clear (wins over enable)
//   en_i     - count enable
//   limit_i  - saturation value
//   done_o   - high while the count equals limit_i
module mux_share_arbiter_hold_counter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [3:0] limit_i,
  output logic       done_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (en_i && (cnt_q < limit_i)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == limit_i);

endmodule

// File: rtl/mux_share_arbiter.sv
// Two-requester round-robin arbiter sharing one WIDTH-bit 2:1 mux path.
// Ports:
//   CLOCK_50     - system clock
//   resetn       - asynchronous active-low reset
//   req_x, req_y - level-sensitive path requests
//   x, y         - source data words
//   gnt_x, gnt_y - one-hot ownership grants
//   sel          - mux select (1 = x, 0 = y), holds while idle
//   m            - registered shared output word
//   busy         - either grant active
module mux_share_arbiter
  import mux_share_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HOLD  = DEF_HOLD
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             req_x,
  input  logic             req_y,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             gnt_x,
  output logic             gnt_y,
  output logic             sel,
  output logic [WIDTH-1:0] m,
  output logic             busy
);

  localparam logic [3:0] HOLD_LIMIT = 4'(HOLD);

  logic [1:0]       state_q, state_d;
  logic             last_x_q, last_x_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             hold_done;
  logic             own_change;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_x && req_y)  state_d = last_x_q ? ST_OWN_Y : ST_OWN_X;
        else if (req_x)      state_d = ST_OWN_X;
        else if (req_y)      state_d = ST_OWN_Y;
      end
      ST_OWN_X: begin
        if (!req_x)          state_d = req_y ? ST_OWN_Y : ST_IDLE;
        else if (req_y && hold_done) state_d = ST_OWN_Y;
      end
      ST_OWN_Y: begin
        if (!req_y)          state_d = req_x ? ST_OWN_X : ST_IDLE;
        else if (req_x && hold_done) state_d = ST_OWN_X;
      end
      default:               state_d = ST_IDLE;
    endcase
  end

  // Data, select and last-owner all follow the next-state owner so they
  // land on the same edge as the grant.
  always_comb begin
    last_x_d = last_x_q;
    sel_d    = sel_q;
    m_d      = '0;
    if (state_d == ST_OWN_X) begin
      last_x_d = 1'b1;
      sel_d    = SEL_X;
      m_d      = x;
    end else if (state_d == ST_OWN_Y) begin
      last_x_d = 1'b0;
      sel_d    = SEL_Y;
      m_d      = y;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      last_x_q <= 1'b0;
      sel_q    <= 1'b0;
      m_q      <= '0;
    end else begin
      state_q  <= state_d;
      last_x_q <= last_x_d;
      sel_q    <= sel_d;
      m_q      <= m_d;
    end
  end

  // Restart the hold count on any ownership change; the IDLE case is
  // cleared too so the count is always fresh when a grant is taken.
  assign own_change = (state_d != state_q) || (state_d == ST_IDLE);

  mux_share_arbiter_hold_counter u_hold (
    .clk_i   (CLOCK_50),
    .rst_ni  (resetn),
    .clr_i   (own_change),
    .en_i    (1'b1),
    .limit_i (HOLD_LIMIT),
    .done_o  (hold_done)
  );

  assign gnt_x = (state_q == ST_OWN_X);
  assign gnt_y = (state_q == ST_OWN_Y);
  assign busy  = gnt_x | gnt_y;
  assign sel   = sel_q;
  assign m     = m_q;

endmodule

// File: doc/mux_share_arbiter.md
# mux_share_arbiter

Two-requester arbiter that shares a single WIDTH-bit 2:1 multiplexer path and its LED output between source X and source Y. It grants the path round-robin, enforces a minimum hold time before a contended switch, and drives the mux select and a registered output word. It sits between the switch/requester logic and the LEDR bank in the lab top level.

## Interface
- WIDTH, 4, data width of each source and of the shared output.
- HOLD, 4, minimum cycles an owner keeps the path while the other side requests; legal range 1..15.
- CLOCK_50  input  1  system clock; all state changes on the rising edge.
- resetn  input  1  reset, asynchronous and active-low.
- req_x  input  1  X requests the path; level-sensitive, held while X wants ownership.
- req_y  input  1  Y requests the path; level-sensitive.
- x  input  WIDTH  X data word.
- y  input  WIDTH  Y data word.
- gnt_x  output  1  X owns the path.
- gnt_y  output  1  Y owns the path.
- sel  output  1  mux select, 1 selects x and 0 selects y; holds its last value when idle.
- m  output  WIDTH  registered shared output word.
- busy  output  1  high whenever either grant is high.

## Operation
- States: IDLE, OWN_X, OWN_Y. One-hot grants; gnt_x and gnt_y are never both 1.
- last_x register records the most recent owner (1 = X).
- IDLE:
  - Only req_x → OWN_X.
  - Only req_y → OWN_Y.
  - Both requesting → the side that was not last owner. After reset last_x=0, so X wins first.
  - Neither requesting → stay in IDLE.
- OWN_X:
  - req_x low and req_y high → OWN_Y.
  - req_x low and req_y low → IDLE.
  - req_x high, req_y high and hold_cnt==HOLD → OWN_Y (fairness switch).
  - Otherwise stay in OWN_X.
- OWN_Y: symmetric to OWN_X.
- hold_cnt:
  - Clears to 0 on every edge where ownership changes, including entry from IDLE.
  - Increments by 1 each cycle ownership is unchanged.
  - Saturates at HOLD.
  - Width is 4 bits.
- m:
  - In OWN_X, m is registered from x; in OWN_Y, from y, selected on the next-state owner.
  - m is 0 on entry to IDLE and while in IDLE.
- sel:
  - Updates on the same edge as the grant: 1 entering OWN_X, 0 entering OWN_Y.
  - Unchanged on entry to IDLE.
- Reset value of every output is 0: gnt_x, gnt_y, sel, m, busy. Reset also clears hold_cnt and last_x and forces the state to IDLE.

## Timing
- Request-to-grant latency is 1 edge. A request sampled high at edge n in IDLE gives the grant visible after edge n.
- m carries the sampled data at that same edge, so data latency is 1 edge and matches the grant.
- While ownership is stable, m follows the owner's data with a 1-cycle delay.
- Contended switch happens at the edge where hold_cnt==HOLD. The owner therefore holds for exactly HOLD+1 cycles against a continuously waiting requester.
- Release is immediate: the edge after the owner's req drops, the path moves to the waiter or to IDLE. There is no dead cycle between owners.
- Simultaneous owner drop and waiter request: switch to the waiter, with hold_cnt cleared.
- Asynchronous reset mid-ownership: outputs are 0 immediately, with no clock needed. The first grant after reset follows the IDLE rules with last_x=0.
- If a requester drops before its grant edge, no grant is issued.

## Structure
- Shared package/header holds:
  - State encoding localparams ST_IDLE, ST_OWN_X, ST_OWN_Y.
  - Defaults for WIDTH and HOLD.
  - SEL_X=1 and SEL_Y=0.
- One natural sub-module: hold_counter, a saturating 4-bit counter with synchronous clear, enable, limit input and a done flag.
- The data mux and the m register stay in the top of this block.

## Test plan
- Reset while in OWN_Y with m=4'hA → gnt_x, gnt_y, sel, m and busy all 0 immediately. Release resetn, assert req_x=req_y=1 → the first grant goes to X.
- IDLE, req_y=1 only, y=4'h5 → after 1 edge gnt_y=1, sel=0, m=4'h5. Then y=4'h9 → m=4'h9 after 1 more edge.
- HOLD=4, both requests held high continuously → gnt_x for 5 cycles, then gnt_y for 5 cycles, alternating. gnt_x and gnt_y are never both 1.
- OWN_X with req_y=1 and hold_cnt=1, drop req_x → gnt_y=1 at the next edge, and hold_cnt restarts at 0.
- OWN_X alone, drop req_x → IDLE next edge: m=0, busy=0, sel stays 1. Then assert both requests → Y wins, since last owner was X.
- req_x pulsed for 1 cycle between edges (never sampled) → no grant; all outputs remain 0.
